// File: rtl/fetch_pkg.sv
// Fetch unit shared types: decode entry bundle,
// controller states and buffer depth.
package fetch_pkg;

  localparam int FETCH_BUF_DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred_taken;
    logic [31:0] pred_pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO between fetch and decode.
// Flush wins over push and pop.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  fetch_entry_t mem [FETCH_BUF_DEPTH];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign full    = count == 2'd2;
  assign empty   = count == 2'd0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= !wr_ptr;
      if (do_pop)  rd_ptr <= !rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns fetch PC, runs the imem handshake,
// kills stale responses on redirect, feeds decode buffer.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] reset_vector = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] fetch_pc,
  input  logic [31:0] pred_next_pc,
  input  logic        pred_taken,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_pred_taken,
  output logic [31:0] out_pred_pc
);

  fetch_state_t state;
  fetch_state_t state_nx;
  fetch_entry_t push_entry;
  fetch_entry_t head;

  logic [31:0] trk_pc;
  logic        trk_taken;
  logic [31:0] trk_pred;

  logic req_fire;
  logic push;
  logic pop;
  logic full;
  logic empty;

  assign imem_req_valid = rst && (state == REQ) && !full;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response racing a redirect is stale and never enters the buffer.
  assign push = (state == WAIT) && imem_rsp_valid && !redirect_valid;
  assign pop  = out_valid && out_ready;

  assign push_entry = '{
    pc:         trk_pc,
    instr:      imem_rsp_data,
    pred_taken: trk_taken,
    pred_pc:    trk_pred
  };

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      state == REQ: begin
        if (req_fire)
          state_nx = redirect_valid ? DRAIN : WAIT;
      end
      state == WAIT: begin
        if (imem_rsp_valid)
          state_nx = REQ;
        else if (redirect_valid)
          state_nx = DRAIN;
      end
      state == DRAIN: begin
        if (imem_rsp_valid)
          state_nx = REQ;
      end
      default: state_nx = REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= REQ;
      fetch_pc  <= reset_vector;
      trk_pc    <= '0;
      trk_taken <= 1'b0;
      trk_pred  <= '0;
    end else begin
      state <= state_nx;
      if (redirect_valid)
        fetch_pc <= redirect_pc;
      else if (req_fire)
        fetch_pc <= pred_next_pc;
      if (req_fire) begin
        trk_pc    <= fetch_pc;
        trk_taken <= pred_taken;
        trk_pred  <= pred_next_pc;
      end
    end
  end

  fetch_buffer u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .flush (redirect_valid),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign out_valid      = !empty;
  assign out_pc         = head.pc;
  assign out_instr      = head.instr;
  assign out_pred_taken = head.pred_taken;
  assign out_pred_pc    = head.pred_pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: memory/predictor model with an
// expected-entry queue, a prediction table and corner sequences.
module tb_fetch_ctrl;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        taken;
    logic [31:0] pred;
  } ent_t;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] pred;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic [31:0] pred_next_pc;
  logic        pred_taken;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_pred_taken;
  logic [31:0] out_pred_pc;

  fetch_ctrl #(.reset_vector(32'h0000_0100)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_pc       (fetch_pc),
    .pred_next_pc   (pred_next_pc),
    .pred_taken     (pred_taken),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_pred_taken (out_pred_taken),
    .out_pred_pc    (out_pred_pc)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   lat   = 1;
  int   rem   = 0;
  int   first_fire = -1;
  bit   live  = 0;
  bit   last_fire = 0;
  bit   force_rsp = 0;
  logic [31:0] exp_pc;
  logic [31:0] maddr;
  logic [31:0] fire_addr;
  ent_t inflight;
  ent_t exp_q [$];
  ent_t got_q [$];
  bit   ov_log [$];
  vec_t tbl [4];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic pt_of(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if (tbl[i].pc == a && tbl[i].taken) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] pn_of(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if (tbl[i].pc == a && tbl[i].taken) return tbl[i].pred;
    return a + 32'd4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act,
                      input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%b want=%b", name, act, exp);
    end
  endtask

  task automatic set_pred();
    pred_taken   = pt_of(fetch_pc);
    pred_next_pc = pn_of(fetch_pc);
  endtask

  task automatic sb_pop();
    ent_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_out: got pc=%h want none", out_pc);
      return;
    end
    e = exp_q.pop_front();
    chk("out_pc", out_pc, e.pc);
    chk("out_instr", out_instr, e.instr);
    chk1("out_pred_taken", out_pred_taken, e.taken);
    chk("out_pred_pc", out_pred_pc, e.pred);
    got_q.push_back('{out_pc, out_instr, out_pred_taken, out_pred_pc});
  endtask

  // One clock: sample handshakes, update model, advance, drive memory.
  task automatic tick();
    logic fire, rsp, pop, rdr;
    fire = imem_req_valid && imem_req_ready;
    rsp  = imem_rsp_valid;
    pop  = out_valid && out_ready;
    rdr  = redirect_valid;
    ov_log.push_back(out_valid);
    last_fire = fire;
    if (pop) sb_pop();
    if (rsp) begin
      if (!rdr && live) exp_q.push_back(inflight);
      live = 0;
    end
    if (fire) begin
      chk("req_addr", imem_req_addr, exp_pc);
      chk("fetch_pc", fetch_pc, exp_pc);
      inflight = '{exp_pc, instr_of(exp_pc), pt_of(exp_pc), pn_of(exp_pc)};
      live = 1;
      maddr = imem_req_addr;
      fire_addr = imem_req_addr;
      if (first_fire < 0) first_fire = cyc;
    end
    if (rdr) begin
      exp_q.delete();
      live = 0;
      exp_pc = redirect_pc;
    end else if (fire) begin
      exp_pc = pn_of(exp_pc);
    end
    @(posedge clk);
    #1;
    cyc++;
    imem_rsp_valid = 1'b0;
    if (fire) rem = lat;
    if (rem > 0) begin
      rem--;
      if (rem == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(maddr);
      end
    end
    if (force_rsp) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      force_rsp = 0;
    end
    set_pred();
  endtask

  task automatic run_deliv(input int n, input int budget, input string name);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (got_q.size() < n) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: delivered=%0d need=%0d",
               name, got_q.size(), n);
    end
  endtask

  task automatic run_fire(input int budget, input string name);
    int k = 0;
    do begin
      tick();
      k++;
    end while (!last_fire && k < budget);
    if (!last_fire) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: no request accepted in %0d cycles",
               name, budget);
    end
  endtask

  initial begin
    tbl[0] = '{32'h100, 1'b0, 32'h104};
    tbl[1] = '{32'h104, 1'b1, 32'h200};
    tbl[2] = '{32'h200, 1'b0, 32'h204};
    tbl[3] = '{32'h204, 1'b0, 32'h208};

    rst = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;
    pred_taken     = 1'b0;
    pred_next_pc   = '0;
    exp_pc         = 32'h100;

    // Async reset before any clock edge
    #2 rst = 1'b0;
    #1;
    chk("rst_fetch_pc", fetch_pc, 32'h100);
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    set_pred();
    tick();
    tick();
    chk1("rst_req_gated", imem_req_valid, 1'b0);

    // Sequential fetch with a taken prediction at 0x104
    rst = 1'b1;
    #1;
    chk1("first_req_valid", imem_req_valid, 1'b1);
    chk("first_req_addr", imem_req_addr, 32'h100);
    first_fire = -1;
    got_q.delete();
    run_deliv(4, 40, "seq");
    if (first_fire >= 0) begin
      for (int i = 1; i <= 6; i++)
        chk1("seq_out_valid_cadence", ov_log[first_fire + i],
             (i % 2) == 0);
    end
    for (int i = 0; i < 4; i++) begin
      chk("tbl_pc", got_q[i].pc, tbl[i].pc);
      chk1("tbl_taken", got_q[i].taken, tbl[i].taken);
      chk("tbl_pred_pc", got_q[i].pred, tbl[i].pred);
    end

    // Backpressure: buffer fills and request issue stops
    got_q.delete();
    out_ready = 1'b0;
    repeat (12) tick();
    chk1("bp_req_valid", imem_req_valid, 1'b0);
    chk1("bp_out_valid", out_valid, 1'b1);
    chk("bp_head_pc", out_pc, 32'h208);
    out_ready = 1'b1;
    run_deliv(2, 20, "bp");
    chk("bp_order0", got_q[0].pc, 32'h208);
    chk("bp_order1", got_q[1].pc, 32'h20C);
    run_fire(10, "bp_resume");

    // Redirect while waiting on a slow memory
    lat = 3;
    run_fire(20, "w_fire");
    redirect_pc    = 32'h400;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk1("w_redir_out_valid", out_valid, 1'b0);
    chk1("w_redir_drain", imem_req_valid, 1'b0);
    got_q.delete();
    run_fire(20, "w_refire");
    chk("w_refire_addr", fire_addr, 32'h400);
    chk("w_no_stale", got_q.size(), 0);

    // Redirect coinciding with the response
    tick();
    tick();
    redirect_pc    = 32'h480;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk1("rr_req_valid", imem_req_valid, 1'b1);
    chk("rr_req_addr", imem_req_addr, 32'h480);
    chk1("rr_out_valid", out_valid, 1'b0);
    got_q.delete();
    run_deliv(1, 20, "rr");
    chk("rr_first_pc", got_q[0].pc, 32'h480);

    // Redirect with a full buffer and a stalled memory
    lat = 1;
    out_ready = 1'b0;
    repeat (12) tick();
    chk1("fb_full_req", imem_req_valid, 1'b0);
    imem_req_ready = 1'b0;
    redirect_pc    = 32'h400;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk1("fb_flushed", out_valid, 1'b0);
    chk1("fb_req_valid", imem_req_valid, 1'b1);
    chk("fb_req_addr", imem_req_addr, 32'h400);
    repeat (3) tick();
    chk("fb_addr_stable", imem_req_addr, 32'h400);
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    got_q.delete();
    run_deliv(1, 20, "fb");
    chk("fb_first_pc", got_q[0].pc, 32'h400);

    // Async reset mid-WAIT, then a late response
    lat = 3;
    run_fire(20, "ar_fire");
    tick();
    #2 rst = 1'b0;
    #1;
    chk1("ar_out_valid", out_valid, 1'b0);
    chk1("ar_req_valid", imem_req_valid, 1'b0);
    chk("ar_fetch_pc", fetch_pc, 32'h100);
    exp_q.delete();
    live = 0;
    rem = 0;
    exp_pc = 32'h100;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    set_pred();
    tick();
    tick();
    rst = 1'b1;
    #1;
    force_rsp = 1;
    repeat (3) tick();
    chk1("ar_late_ignored", out_valid, 1'b0);
    chk1("ar_req_valid_after", imem_req_valid, 1'b1);
    chk("ar_req_addr_after", imem_req_addr, 32'h100);
    imem_req_ready = 1'b1;
    got_q.delete();
    run_deliv(1, 20, "ar");
    chk("ar_restart_pc", got_q[0].pc, 32'h100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the fetch datapath. Owns the fetch PC and drives the instruction-memory request/response handshake. Advances the PC using the next-PC supplied by the BTB/BPU prediction logic and handles redirects from execute, including killing in-flight responses. Delivers fetched instructions with their prediction metadata to decode through a 2-entry buffer with valid/ready backpressure.

## Interface
Parameters:
- reset_vector, 32'h0000_0000, PC loaded on reset

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous reset, active-low (asserted when 0)
- fetch_pc  out  32  current fetch PC, used as the query address of the prediction logic
- pred_next_pc  in  32  predicted successor of fetch_pc: BTB target if hit and taken, else fetch_pc+4
- pred_taken  in  1  prediction for fetch_pc was taken
- imem_req_valid  out  1  instruction request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  request address, always equal to fetch_pc
- imem_rsp_valid  in  1  response valid; always accepted, no ready
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  execute-stage redirect (mispredict or exception)
- redirect_pc  in  32  redirect target
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode accepts
- out_pc  out  32  PC of the delivered instruction
- out_instr  out  32  instruction word
- out_pred_taken  out  1  prediction recorded at fetch
- out_pred_pc  out  32  predicted next PC recorded at fetch

## Operation
- States: REQ (may issue), WAIT (one request outstanding), DRAIN (outstanding response is stale and must be discarded).
- REQ: imem_req_valid = !buf_full. On handshake: latch {fetch_pc, pred_taken, pred_next_pc} into the in-flight tracker, set fetch_pc <= pred_next_pc, go to WAIT. With no handshake, stay in REQ; addr/valid stay stable until accepted or until a redirect occurs.
- WAIT: on imem_rsp_valid, push {tracker.pc, rsp_data, tracker.pred_taken, tracker.pred_pc} into the buffer and go to REQ. The tracker invariant guarantees the buffer has space.
- DRAIN: on imem_rsp_valid, drop the response and go to REQ.
- Redirect has the highest priority and takes effect in any state:
  - fetch_pc <= redirect_pc.
  - Buffer is flushed, so out_valid=0 next cycle.
  - From REQ: an unaccepted request is abandoned; a request accepted in the same cycle becomes stale, go to DRAIN.
  - From WAIT: if imem_rsp_valid arrives the same cycle, drop it and go to REQ; otherwise go to DRAIN.
  - From DRAIN: stay in DRAIN. If the stale response arrives the same cycle, go to REQ.
- At most one outstanding request. Peak throughput is 1 instruction per 2 cycles.
- Buffer: 2-entry FIFO. Pop on out_valid && out_ready. Simultaneous push and pop while full is impossible, because REQ blocks issue when full. Flush has priority over push and pop.
- All PCs are 32-bit; the block performs no arithmetic beyond buffer pointer/count wrap (1-bit pointers, 2-bit count).

## Timing
- Reset (rst=0): fetch_pc=reset_vector, state REQ, buffer empty, imem_req_valid=0, out_valid=0, tracker cleared. imem_req_valid is gated low while rst=0.
- First request is visible in the first cycle after rst deasserts.
- Latency: request accepted in cycle N, response in cycle N+k (k≥1), out_valid in cycle N+k+1.
- Redirect in cycle N: imem_req_addr=redirect_pc in cycle N+1 if state becomes REQ; otherwise after the stale response.
- out_* are driven from the buffer head (registered). out_valid holds with stable data until accepted or flushed.
- Reset asserted mid-operation: all state returns to reset values immediately. A response arriving after reset release with no request outstanding is ignored.

## Structure
- fetch_pkg: fetch_entry_t struct {pc, instr, pred_taken, pred_pc}; fetch_state_t enum {REQ, WAIT, DRAIN}; FETCH_BUF_DEPTH=2.
- Sub-module fetch_buffer: 2-entry FIFO of fetch_entry_t with push, pop, flush, full, empty.
- Top-level fetch_ctrl holds the FSM, fetch_pc and the tracker.

## Test plan
- Sequential fetch: reset_vector=0x100, pred_next_pc=fetch_pc+4, memory ready with 1-cycle latency, out_ready=1 → out_pc 0x100, 0x104, 0x108 with out_valid on alternating cycles starting 2 cycles after the first handshake.
- Predicted taken: at 0x104, pred_taken=1 and pred_next_pc=0x200 → next imem_req_addr=0x200; entry 0x104 carries out_pred_taken=1, out_pred_pc=0x200.
- Backpressure: out_ready=0 → two entries buffer, imem_req_valid drops to 0 while full. Releasing out_ready drains them in order and resumes requests.
- Redirect while WAIT with a 3-cycle memory: redirect_pc=0x400 → stale response dropped (no out_valid), next request addr 0x400. Same test with the redirect coinciding with imem_rsp_valid → immediate REQ at 0x400.
- Redirect with a full buffer and a stalled request (imem_req_ready=0) → buffer flushed next cycle, imem_req_addr=0x400, no stale entries delivered.
- Async reset asserted mid-WAIT → outputs return to reset values without a clock edge. Fetch restarts at reset_vector after release, and a late response is ignored.
